// File: rtl/branch_resolve_unit.sv
// Resolves execute-stage control flow against the frontend prediction, emits predictor updates and
// redirects, and ignores wrong-path instructions for SHADOW_CYCLES after a flush. Optional counters: BRU_PERF_CNT_EN.
module branch_resolve_unit #(
    parameter int ADDR_WIDTH    = 32,
    parameter int SHADOW_CYCLES = 2
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic                  ex_valid,
    input  logic                  ex_kill,
    input  logic [ADDR_WIDTH-1:0] ex_pc,
    input  logic                  ex_branch,
    input  logic                  ex_jal,
    input  logic                  ex_jalr,
    input  logic                  ex_call,
    input  logic                  ex_ret,
    input  logic                  ex_cond,
    input  logic [ADDR_WIDTH-1:0] ex_target,
    input  logic                  ex_pred_taken,
    input  logic [ADDR_WIDTH-1:0] ex_pred_pc,
    output logic                  bpu_valid,
    output logic                  bpu_flush,
    output logic [ADDR_WIDTH-1:0] bpu_target,
    output logic                  bpu_taken,
    output logic                  bpu_call,
    output logic                  bpu_ret,
    output logic [ADDR_WIDTH-1:0] bpu_pc,
    output logic                  shadow
`ifdef BRU_PERF_CNT_EN
    ,
    output logic [31:0]           perf_br_cnt,
    output logic [31:0]           perf_mis_cnt
`endif
);

    typedef enum logic {IDLE, SHADOW} state_t;

    localparam logic [3:0] SHADOW_LOAD = 4'(SHADOW_CYCLES);

    state_t                state_reg, state_next;
    logic [3:0]            shadow_cnt_reg, shadow_cnt_next;
    logic                  ctrl, act_taken, alias_hit, mispredict, accept;
    logic [ADDR_WIDTH-1:0] pc_plus4, act_next;

    assign ctrl       = ex_branch | ex_jal | ex_jalr;
    assign act_taken  = ex_jal | ex_jalr | (ex_branch & ex_cond);
    // A predicted-taken non-control instruction is a predictor alias and must be undone.
    assign alias_hit  = ~ctrl & ex_pred_taken;
    assign pc_plus4   = ex_pc + ADDR_WIDTH'(4);
    assign act_next   = act_taken ? ex_target : pc_plus4;
    assign mispredict = alias_hit | (act_taken != ex_pred_taken) |
                        (act_taken & (ex_target != ex_pred_pc));
    assign accept     = ex_valid & ~ex_kill & (state_reg == IDLE) & (ctrl | alias_hit);

    always_comb begin
        state_next      = state_reg;
        shadow_cnt_next = shadow_cnt_reg;
        if (ex_kill) begin
            state_next      = IDLE;
            shadow_cnt_next = 4'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept && mispredict) begin
                        state_next      = SHADOW;
                        shadow_cnt_next = SHADOW_LOAD;
                    end
                end
                SHADOW: begin
                    if (shadow_cnt_reg <= 4'd1) begin
                        state_next      = IDLE;
                        shadow_cnt_next = 4'd0;
                    end else begin
                        shadow_cnt_next = shadow_cnt_reg - 4'd1;
                    end
                end
                default: begin
                    state_next      = IDLE;
                    shadow_cnt_next = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_reg      <= IDLE;
            shadow_cnt_reg <= 4'd0;
            shadow         <= 1'b0;
        end else begin
            state_reg      <= state_next;
            shadow_cnt_reg <= shadow_cnt_next;
            shadow         <= (state_next == SHADOW);
        end
    end

    // Strobes clear every cycle; target and pc only change on an accepted instruction.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            bpu_valid  <= 1'b0;
            bpu_flush  <= 1'b0;
            bpu_taken  <= 1'b0;
            bpu_call   <= 1'b0;
            bpu_ret    <= 1'b0;
            bpu_target <= '0;
            bpu_pc     <= '0;
        end else begin
            bpu_valid <= accept;
            bpu_flush <= accept & mispredict;
            bpu_taken <= accept & act_taken;
            bpu_call  <= accept & ex_call & ctrl;
            bpu_ret   <= accept & ex_ret & ctrl;
            if (accept) begin
                bpu_pc     <= ex_pc;
                bpu_target <= mispredict ? act_next : ex_target;
            end
        end
    end

`ifdef BRU_PERF_CNT_EN
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            perf_br_cnt  <= 32'd0;
            perf_mis_cnt <= 32'd0;
        end else begin
            if (accept)
                perf_br_cnt <= perf_br_cnt + 32'd1;
            if (accept && mispredict)
                perf_mis_cnt <= perf_mis_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit; perf counter scenario built only with BRU_PERF_CNT_EN.
module tb_branch_resolve_unit;

    localparam int AW = 32;

    logic          CLK = 1'b0;
    logic          RSTN;
    logic          ex_valid, ex_kill, ex_branch, ex_jal, ex_jalr, ex_call, ex_ret, ex_cond, ex_pred_taken;
    logic [AW-1:0] ex_pc, ex_target, ex_pred_pc;
    logic          bpu_valid, bpu_flush, bpu_taken, bpu_call, bpu_ret, shadow;
    logic [AW-1:0] bpu_target, bpu_pc;
`ifdef BRU_PERF_CNT_EN
    logic [31:0]   perf_br_cnt, perf_mis_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    branch_resolve_unit #(.ADDR_WIDTH(AW), .SHADOW_CYCLES(2)) dut (
        .CLK(CLK), .RSTN(RSTN),
        .ex_valid(ex_valid), .ex_kill(ex_kill), .ex_pc(ex_pc),
        .ex_branch(ex_branch), .ex_jal(ex_jal), .ex_jalr(ex_jalr),
        .ex_call(ex_call), .ex_ret(ex_ret), .ex_cond(ex_cond),
        .ex_target(ex_target), .ex_pred_taken(ex_pred_taken), .ex_pred_pc(ex_pred_pc),
        .bpu_valid(bpu_valid), .bpu_flush(bpu_flush), .bpu_target(bpu_target),
        .bpu_taken(bpu_taken), .bpu_call(bpu_call), .bpu_ret(bpu_ret),
        .bpu_pc(bpu_pc), .shadow(shadow)
`ifdef BRU_PERF_CNT_EN
        , .perf_br_cnt(perf_br_cnt), .perf_mis_cnt(perf_mis_cnt)
`endif
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        ex_valid = 0; ex_kill = 0; ex_branch = 0; ex_jal = 0; ex_jalr = 0;
        ex_call = 0; ex_ret = 0; ex_cond = 0; ex_pred_taken = 0;
        ex_pc = '0; ex_target = '0; ex_pred_pc = '0;
    endtask

    // kind: 0 none, 1 branch, 2 jal, 3 jalr
    task automatic drive(input int kind, input logic cond, input logic [AW-1:0] pc,
                         input logic [AW-1:0] tgt, input logic pt, input logic [AW-1:0] ppc,
                         input logic call, input logic ret);
        ex_valid = 1; ex_kill = 0;
        ex_branch = (kind == 1); ex_jal = (kind == 2); ex_jalr = (kind == 3);
        ex_cond = cond; ex_pc = pc; ex_target = tgt; ex_pred_taken = pt; ex_pred_pc = ppc;
        ex_call = call; ex_ret = ret;
    endtask

    task automatic test_reset();
        RSTN = 0;
        idle_inputs();
        repeat (3) step();
        n_checks++;
        if ({bpu_valid, bpu_flush, bpu_taken, bpu_call, bpu_ret, shadow} !== 6'b0 ||
            bpu_target !== '0 || bpu_pc !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b f=%b t=%b c=%b r=%b s=%b tgt=%h pc=%h, want all 0",
                     bpu_valid, bpu_flush, bpu_taken, bpu_call, bpu_ret, shadow, bpu_target, bpu_pc);
        end
        RSTN = 1;
        step();
        $display("test_reset done");
    endtask

    task automatic test_correct_taken();
        drive(1, 1, 32'h100, 32'h180, 1, 32'h180, 0, 0);
        step();
        idle_inputs();
        n_checks++;
        if (!(bpu_valid === 1 && bpu_flush === 0 && bpu_taken === 1 && bpu_target === 32'h180 &&
              bpu_pc === 32'h100 && shadow === 0)) begin
            n_fail++;
            $display("FAIL correct_taken: got v=%b f=%b t=%b tgt=%h pc=%h s=%b, want 1 0 1 180 100 0",
                     bpu_valid, bpu_flush, bpu_taken, bpu_target, bpu_pc, shadow);
        end
        step();
        n_checks++;
        if (!(bpu_valid === 0 && bpu_taken === 0 && bpu_target === 32'h180 && bpu_pc === 32'h100)) begin
            n_fail++;
            $display("FAIL hold_after_update: got v=%b t=%b tgt=%h pc=%h, want 0 0 180 100",
                     bpu_valid, bpu_taken, bpu_target, bpu_pc);
        end
        $display("test_correct_taken done");
    endtask

    task automatic test_not_taken_mispredict();
        drive(1, 0, 32'h200, 32'h280, 1, 32'h280, 0, 0);
        step();
        // Keep a correctly predicted branch on the bus: it must be ignored during shadow.
        drive(1, 1, 32'h210, 32'h300, 1, 32'h300, 0, 0);
        n_checks++;
        if (!(bpu_valid === 1 && bpu_flush === 1 && bpu_target === 32'h204 && bpu_taken === 0 &&
              shadow === 1)) begin
            n_fail++;
            $display("FAIL nt_mispredict: got v=%b f=%b tgt=%h t=%b s=%b, want 1 1 204 0 1",
                     bpu_valid, bpu_flush, bpu_target, bpu_taken, shadow);
        end
        step();
        n_checks++;
        if (!(bpu_valid === 0 && shadow === 1)) begin
            n_fail++;
            $display("FAIL shadow_cycle1: got v=%b s=%b, want 0 1", bpu_valid, shadow);
        end
        step();
        n_checks++;
        if (!(bpu_valid === 0 && shadow === 0 && bpu_target === 32'h204)) begin
            n_fail++;
            $display("FAIL shadow_cycle2: got v=%b s=%b tgt=%h, want 0 0 204", bpu_valid, shadow, bpu_target);
        end
        step();
        idle_inputs();
        n_checks++;
        if (!(bpu_valid === 1 && bpu_flush === 0 && bpu_pc === 32'h210 && bpu_target === 32'h300)) begin
            n_fail++;
            $display("FAIL after_shadow: got v=%b f=%b pc=%h tgt=%h, want 1 0 210 300",
                     bpu_valid, bpu_flush, bpu_pc, bpu_target);
        end
        step();
        $display("test_not_taken_mispredict done");
    endtask

    task automatic test_jalr_wrong_target();
        drive(3, 0, 32'h300, 32'h400, 1, 32'h3F0, 0, 1);
        step();
        idle_inputs();
        n_checks++;
        if (!(bpu_valid === 1 && bpu_flush === 1 && bpu_target === 32'h400 && bpu_ret === 1 &&
              bpu_call === 0 && bpu_taken === 1)) begin
            n_fail++;
            $display("FAIL jalr_target: got v=%b f=%b tgt=%h r=%b c=%b t=%b, want 1 1 400 1 0 1",
                     bpu_valid, bpu_flush, bpu_target, bpu_ret, bpu_call, bpu_taken);
        end
        repeat (2) step();
        $display("test_jalr_wrong_target done");
    endtask

    task automatic test_alias_wrap();
        drive(0, 0, 32'hFFFF_FFFC, 32'h1234, 1, 32'h1234, 1, 0);
        step();
        idle_inputs();
        n_checks++;
        if (!(bpu_valid === 1 && bpu_flush === 1 && bpu_target === 32'h0 && bpu_taken === 0 &&
              bpu_call === 0 && bpu_pc === 32'hFFFF_FFFC)) begin
            n_fail++;
            $display("FAIL alias_wrap: got v=%b f=%b tgt=%h t=%b c=%b pc=%h, want 1 1 0 0 0 fffffffc",
                     bpu_valid, bpu_flush, bpu_target, bpu_taken, bpu_call, bpu_pc);
        end
        repeat (2) step();
        drive(0, 0, 32'h700, 32'h740, 0, 32'h0, 0, 0);
        step();
        idle_inputs();
        n_checks++;
        if (!(bpu_valid === 0 && bpu_flush === 0 && shadow === 0)) begin
            n_fail++;
            $display("FAIL non_control: got v=%b f=%b s=%b, want 0 0 0", bpu_valid, bpu_flush, shadow);
        end
        $display("test_alias_wrap done");
    endtask

    task automatic test_back_to_back();
        drive(2, 0, 32'h800, 32'h900, 1, 32'h900, 1, 0);
        step();
        drive(1, 0, 32'h804, 32'h880, 0, 32'h0, 0, 0);
        n_checks++;
        if (!(bpu_valid === 1 && bpu_flush === 0 && bpu_call === 1 && bpu_taken === 1 && bpu_pc === 32'h800)) begin
            n_fail++;
            $display("FAIL b2b_jal_call: got v=%b f=%b c=%b t=%b pc=%h, want 1 0 1 1 800",
                     bpu_valid, bpu_flush, bpu_call, bpu_taken, bpu_pc);
        end
        step();
        idle_inputs();
        n_checks++;
        if (!(bpu_valid === 1 && bpu_flush === 0 && bpu_taken === 0 && bpu_call === 0 &&
              bpu_target === 32'h880 && bpu_pc === 32'h804)) begin
            n_fail++;
            $display("FAIL b2b_not_taken: got v=%b f=%b t=%b c=%b tgt=%h pc=%h, want 1 0 0 0 880 804",
                     bpu_valid, bpu_flush, bpu_taken, bpu_call, bpu_target, bpu_pc);
        end
        step();
        $display("test_back_to_back done");
    endtask

    task automatic test_kill_shadow();
        drive(1, 0, 32'h500, 32'h580, 1, 32'h580, 0, 0);
        step();
        // Kill while the flush update is still on the outputs; a valid branch alongside must be dropped.
        drive(1, 1, 32'h510, 32'h520, 1, 32'h520, 0, 0);
        ex_kill = 1;
        n_checks++;
        if (!(bpu_valid === 1 && bpu_flush === 1 && shadow === 1)) begin
            n_fail++;
            $display("FAIL kill_pending: got v=%b f=%b s=%b, want 1 1 1", bpu_valid, bpu_flush, shadow);
        end
        step();
        drive(1, 1, 32'h600, 32'h640, 1, 32'h640, 0, 0);
        n_checks++;
        if (!(shadow === 0 && bpu_valid === 0 && bpu_pc === 32'h500)) begin
            n_fail++;
            $display("FAIL kill_clears: got s=%b v=%b pc=%h, want 0 0 500", shadow, bpu_valid, bpu_pc);
        end
        step();
        idle_inputs();
        n_checks++;
        if (!(bpu_valid === 1 && bpu_flush === 0 && bpu_target === 32'h640 && bpu_pc === 32'h600)) begin
            n_fail++;
            $display("FAIL kill_then_update: got v=%b f=%b tgt=%h pc=%h, want 1 0 640 600",
                     bpu_valid, bpu_flush, bpu_target, bpu_pc);
        end
        step();
        $display("test_kill_shadow done");
    endtask

    task automatic test_reset_shadow();
        drive(1, 0, 32'hA00, 32'hA80, 1, 32'hA80, 0, 0);
        step();
        #2 RSTN = 0;
        #1;
        n_checks++;
        if ({bpu_valid, bpu_flush, bpu_taken, bpu_call, bpu_ret, shadow} !== 6'b0 ||
            bpu_target !== '0 || bpu_pc !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got v=%b f=%b t=%b s=%b tgt=%h pc=%h, want all 0",
                     bpu_valid, bpu_flush, bpu_taken, shadow, bpu_target, bpu_pc);
        end
        step();
        RSTN = 1;
        drive(1, 1, 32'hB00, 32'hB40, 1, 32'hB40, 0, 0);
        n_checks++;
        if (!(bpu_valid === 0 && shadow === 0)) begin
            n_fail++;
            $display("FAIL reset_release: got v=%b s=%b, want 0 0", bpu_valid, shadow);
        end
        step();
        idle_inputs();
        n_checks++;
        if (!(bpu_valid === 1 && bpu_flush === 0 && bpu_pc === 32'hB00 && shadow === 0)) begin
            n_fail++;
            $display("FAIL first_after_reset: got v=%b f=%b pc=%h s=%b, want 1 0 b00 0",
                     bpu_valid, bpu_flush, bpu_pc, shadow);
        end
        step();
        $display("test_reset_shadow done");
    endtask

`ifdef BRU_PERF_CNT_EN
    task automatic test_perf_counters();
        RSTN = 0;
        step();
        RSTN = 1;
        for (int i = 0; i < 4; i++) begin
            if (i == 2)
                drive(1, 0, 32'hC00 + 32'(i * 16), 32'hD00, 1, 32'hD00, 0, 0);
            else
                drive(1, 1, 32'hC00 + 32'(i * 16), 32'hD00, 1, 32'hD00, 0, 0);
            step();
            idle_inputs();
            repeat (3) step();
        end
        n_checks++;
        if (!(perf_br_cnt === 32'd4 && perf_mis_cnt === 32'd1)) begin
            n_fail++;
            $display("FAIL perf_counts: got br=%0d mis=%0d, want 4 1", perf_br_cnt, perf_mis_cnt);
        end
        $display("test_perf_counters done");
    endtask
`endif

    initial begin
        test_reset();
        test_correct_taken();
        test_not_taken_mispredict();
        test_jalr_wrong_target();
        test_alias_wrap();
        test_back_to_back();
        test_kill_shadow();
        test_reset_shadow();
`ifdef BRU_PERF_CNT_EN
        test_perf_counters();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 SHALL provide parameter ADDR_WIDTH, default 32: PC and target width.
REQ-002 SHALL provide parameter SHADOW_CYCLES, default 2: wrong-path cycles ignored after a flush; legal range 1..15.
REQ-003 SHALL provide ports:
- CLK  in  1  clock
- RSTN  in  1  reset, asynchronous, active-low
- ex_valid  in  1  execute-stage instruction valid this cycle
- ex_kill  in  1  external pipeline kill (exception/trap)
- ex_pc  in  ADDR_WIDTH  instruction PC
- ex_branch / ex_jal / ex_jalr  in  1 each  instruction class, at most one high
- ex_call / ex_ret  in  1 each  call/return hint
- ex_cond  in  1  conditional-branch outcome
- ex_target  in  ADDR_WIDTH  computed taken target
- ex_pred_taken  in  1  frontend predicted taken
- ex_pred_pc  in  ADDR_WIDTH  frontend predicted next PC
- bpu_valid  out  1  predictor update strobe
- bpu_flush  out  1  mispredict redirect
- bpu_target  out  ADDR_WIDTH  redirect PC on flush, else resolved target
- bpu_taken / bpu_call / bpu_ret  out  1 each  resolved outcome and hints
- bpu_pc  out  ADDR_WIDTH  resolved instruction PC
- shadow  out  1  high while in SHADOW state

Function
REQ-004 SHALL treat ctrl = ex_branch|ex_jal|ex_jalr; act_taken = ex_jal | ex_jalr | (ex_branch & ex_cond).
REQ-005 SHALL compute act_next = act_taken ? ex_target : ex_pc+4, modulo 2^ADDR_WIDTH (0xFFFFFFFC+4 = 0x00000000).
REQ-006 SHALL flag mispredict when act_taken != ex_pred_taken, or act_taken and ex_target != ex_pred_pc.
REQ-007 SHALL flag mispredict for a non-control instruction with ex_pred_taken=1 (alias), redirect to ex_pc+4, bpu_taken=0.
REQ-008 SHALL accept an instruction only when ex_valid=1, ex_kill=0, state=IDLE, and (ctrl or alias).
REQ-009 SHALL register all outputs; an accepted instruction drives bpu_valid=1 for exactly one cycle, the cycle after acceptance.
REQ-010 SHALL drive bpu_flush=1 with bpu_valid iff mispredict; bpu_target = act_next when flushing, ex_target otherwise.
REQ-011 SHALL drive bpu_pc=ex_pc, bpu_taken=act_taken, bpu_call=ex_call&ctrl, bpu_ret=ex_ret&ctrl for accepted instructions.
REQ-012 SHALL hold bpu_target/bpu_pc stable when bpu_valid=0; bpu_flush, bpu_taken, bpu_call, bpu_ret SHALL be 0 when bpu_valid=0.
REQ-013 SHALL implement FSM IDLE/SHADOW: IDLE->SHADOW on accepted mispredict; SHADOW counts SHADOW_CYCLES cycles then ->IDLE.
REQ-014 SHALL ignore ex_valid entirely in SHADOW (no update, no nested flush, counter not reloaded).
REQ-015 SHALL, on ex_kill=1, force IDLE, clear the shadow counter, and suppress acceptance that cycle; an update already registered is still emitted.
REQ-016 SHALL produce no output for non-control, non-alias instructions.

Reset
REQ-017 SHALL on RSTN=0 asynchronously set all outputs 0, state IDLE, shadow counter 0.
REQ-018 SHALL, on reset asserted mid-SHADOW or with a pending update, discard both; first update possible the cycle after the first accepting edge post-release.

Configuration
REQ-019 SHALL, with BRU_PERF_CNT_EN defined, add outputs perf_br_cnt and perf_mis_cnt (32 bits each): increment per accepted instruction / per mispredict, wrap at 2^32, reset 0.
REQ-020 SHALL, without BRU_PERF_CNT_EN, omit both ports and counters; all other behaviour identical.

Verification
REQ-021 Correct taken: ex_branch=1, ex_cond=1, pc=0x100, target=0x180, pred_taken=1, pred_pc=0x180 -> next cycle bpu_valid=1, flush=0, taken=1, bpu_target=0x180.
REQ-022 Not-taken mispredict: ex_branch=1, cond=0, pc=0x200, pred_taken=1 -> bpu_flush=1, bpu_target=0x204, taken=0; shadow=1 for 2 cycles; ex_valid in those cycles produces no bpu_valid.
REQ-023 Wrong JALR target: ex_jalr=1, ex_ret=1, target=0x400, pred_taken=1, pred_pc=0x3F0 -> flush=1, bpu_target=0x400, bpu_ret=1.
REQ-024 Alias plus wrap: non-control, pc=0xFFFFFFFC, pred_taken=1 -> flush=1, bpu_target=0x00000000, taken=0.
REQ-025 Kill/reset in SHADOW: trigger mispredict, assert ex_kill next cycle -> shadow=0 immediately, valid branch following cycle updates; repeat with RSTN pulse -> all outputs 0.
REQ-026 With BRU_PERF_CNT_EN: 3 correct + 1 mispredict branches spaced beyond shadow -> perf_br_cnt=4, perf_mis_cnt=1.
